seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder_pkg.sv | 37 +++
 rtl/seq_chunk_adder_chunk.sv | 28 ++
 rtl/seq_chunk_adder.sv | 143 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package seq_adder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of chunks; guarded so an illegal CHUNK=0 cannot divide by zero
  // before the legality check reports it.
  function automatic int nchunk_of(input int width, input int chunk);
    if (chunk > 0) begin
      return width / chunk;
    end else begin
      return 1;
    end
  endfunction

  // Chunk counter width: clog2(NCHUNK), never narrower than one bit.
  function automatic int cnt_width(input int nchunk);
    if (nchunk <= 1) begin
      return 1;
    end else begin
      return $clog2(nchunk);
    end
  endfunction

  function automatic bit params_legal(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // One-bit full adder, returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top
// bit so the parent can form the signed-overflow flag.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  import seq_adder_pkg::*;

  logic c_v;

  // Ripple the carry through one full adder per bit.
  always_comb begin
    s     = '0;
    c_v   = cin;
    for (int i = 0; i < CHUNK - 1; i++) begin
      {c_v, s[i]} = full_add(a[i], b[i], c_v);
    end
    c_msb = c_v;
    {cout, s[CHUNK-1]} = full_add(a[CHUNK-1], b[CHUNK-1], c_v);
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with the
// inter-chunk carry held in a flop, behind a start/busy/done handshake.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);
  import seq_adder_pkg::*;

  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  generate
    if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
      $error("seq_chunk_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
    end
  endgenerate

  state_t           state_r, state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry_out_r, ovf_r, busy_r, done_r;
  logic             busy_nx_s, done_nx_s;
  logic             accept_s, last_s;
  logic [CHUNK-1:0] a_chunk_s, b_chunk_s, s_chunk_s;
  logic             cout_s, c_msb_s;

  assign accept_s = start & ~busy_r;
  assign last_s   = (state_r == RUN) && (cnt_r == LAST_CNT);

  // Select the operand chunk addressed by the counter.
  always_comb begin
    a_chunk_s = a_r[cnt_r*CHUNK +: CHUNK];
    b_chunk_s = b_r[cnt_r*CHUNK +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_chunk_s),
    .b     (b_chunk_s),
    .cin   (carry_r),
    .s     (s_chunk_s),
    .cout  (cout_s),
    .c_msb (c_msb_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state: IDLE waits for accept, RUN returns after the last chunk.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE:    state_nx_s = accept_s ? RUN : IDLE;
      RUN:     state_nx_s = last_s ? IDLE : RUN;
      default: state_nx_s = IDLE;
    endcase
  end

  // Handshake decode; the result is registered so busy/done are flop outputs.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_nx_s = accept_s;
        done_nx_s = 1'b0;
      end
      RUN: begin
        busy_nx_s = ~last_s;
        done_nx_s = last_s;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  // Operand capture on accept, then one chunk per cycle into Sum; the carry
  // flop carries between chunks and the final flags latch on the last chunk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (accept_s) begin
      a_r     <= A;
      b_r     <= sub ? ~B : B;
      carry_r <= sub ? 1'b1 : Cin;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      sum_r[cnt_r*CHUNK +: CHUNK] <= s_chunk_s;
      carry_r <= cout_s;
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        carry_out_r <= cout_s;
        ovf_r       <= c_msb_s ^ cout_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign Sum      = sum_r;
  assign Carry    = carry_out_r;
  assign Overflow = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 32/8 main instance plus 32/32 and
// 8/1 instances sharing the same stimulus.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rstn, start, sub, Cin;
  logic [31:0] A, B;

  logic        busy_m, done_m, carry_m, ovf_m;
  logic [31:0] sum_m;
  logic        busy_w, done_w, carry_w, ovf_w;
  logic [31:0] sum_w;
  logic        busy_b, done_b, carry_b, ovf_b;
  logic [7:0]  sum_b;

  int errors = 0;
  int checks = 0;
  int lat_m, lat_w, lat_b, pulses_m;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .busy(busy_m), .done(done_m), .Sum(sum_m), .Carry(carry_m), .Overflow(ovf_m)
  );

  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut_w (
    .clk(clk), .rstn(rstn), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .busy(busy_w), .done(done_w), .Sum(sum_w), .Carry(carry_w), .Overflow(ovf_w)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .sub(sub), .A(A[7:0]), .B(B[7:0]), .Cin(Cin),
    .busy(busy_b), .done(done_b), .Sum(sum_b), .Carry(carry_b), .Overflow(ovf_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one operation and watch 12 cycles, recording each instance's latency.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic s);
    @(negedge clk);
    A = a; B = b; Cin = cin; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat_m = 0; lat_w = 0; lat_b = 0; pulses_m = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done_m) pulses_m++;
      if (done_m && lat_m == 0) lat_m = k;
      if (done_w && lat_w == 0) lat_w = k;
      if (done_b && lat_b == 0) lat_b = k;
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0012, 32'h0000_0023, 1'b0, 1'b0, 32'h0000_0035, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};

    rstn = 1'b0; start = 1'b0; sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy_m, 0);
    chk("reset done", done_m, 0);
    chk("reset sum", sum_m, 0);
    chk("reset carry", carry_m, 0);
    chk("reset ovf", ovf_m, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven operations on the 32/8 instance.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk($sformatf("vec%0d latency", i), lat_m, 4);
      chk($sformatf("vec%0d done pulses", i), pulses_m, 1);
      chk($sformatf("vec%0d sum", i), sum_m, vecs[i].sum);
      chk($sformatf("vec%0d carry", i), carry_m, vecs[i].carry);
      chk($sformatf("vec%0d ovf", i), ovf_m, vecs[i].ovf);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    A = 32'h12; B = 32'h23; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    A = 32'h1000; B = 32'h2000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ignore busy", busy_m, 1);
    @(posedge clk);
    #1 chk("ignore done early", done_m, 0);
    @(posedge clk);
    #1 chk("ignore done on time", done_m, 1);
    chk("ignore sum", sum_m, 32'h35);
    @(negedge clk);
    A = 32'h100; B = 32'h200; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b done dropped", done_m, 0);
    chk("b2b busy", busy_m, 1);
    lat_m = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (done_m && lat_m == 0) lat_m = k;
    end
    chk("b2b latency", lat_m, 4);
    chk("b2b sum", sum_m, 32'h300);

    // Asynchronous reset in the second RUN cycle.
    @(negedge clk);
    A = 32'h1111_1111; B = 32'h2222_2222; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midreset busy", busy_m, 0);
    chk("midreset done", done_m, 0);
    chk("midreset sum", sum_m, 0);
    chk("midreset carry", carry_m, 0);
    chk("midreset ovf", ovf_m, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pulses_m = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done_m) pulses_m++;
    end
    chk("midreset no done", pulses_m, 0);
    run_op(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
    chk("post-reset latency", lat_m, 4);
    chk("post-reset sum", sum_m, 32'h3333_3334);

    // Single-chunk and bit-serial instances.
    run_op(32'h0000_00AF, 32'h0000_0001, 1'b0, 1'b0);
    chk("wide latency", lat_w, 1);
    chk("wide sum", sum_w, 32'h0000_00B0);
    chk("serial latency", lat_b, 8);
    chk("serial sum", sum_b, 8'hB0);
    chk("serial carry", carry_b, 0);
    chk("main sum AF", sum_m, 32'h0000_00B0);
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    chk("serial wrap sum", sum_b, 8'h00);
    chk("serial wrap carry", carry_b, 1);
    chk("wide FF sum", sum_w, 32'h0000_0100);
    run_op(32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0);
    chk("serial ovf sum", sum_b, 8'h80);
    chk("serial ovf", ovf_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
